// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: one request at a time, byte-splits misaligned
// stores, double-reads line-crossing loads, sign/zero-extends load data.
`timescale 1ns/1ps
module lsu_ctrl #(
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wData,
   input  logic [31:0] ram_rData
);

   typedef enum logic [2:0] {IDLE, ST, LD0, LD1, DONE} state_t;

   state_t      state_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  cnt_q;
   logic [31:0] lo_q;
   logic [1:0]  ram_we_q;
   logic [31:0] ram_addr_q;
   logic [31:0] ram_wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [1:0]  cnt_d;

   function automatic logic legal(input logic st, input logic [2:0] f3);
      if (st) return f3 inside {3'b000, 3'b001, 3'b010};
      return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   endfunction

   function automatic logic aligned(input logic [2:0] f3, input logic [1:0] off);
      return (f3[1:0] == 2'b00) || (f3[1:0] == 2'b01 && !off[0]) || (off == 2'b00);
   endfunction

   function automatic logic crossing(input logic [2:0] f3, input logic [1:0] off);
      return (f3[1:0] == 2'b01 && off == 2'b11) || (f3[1:0] == 2'b10 && off != 2'b00);
   endfunction

   // index of the final byte of a split store: 0, 1 or 3
   function automatic logic [1:0] last_idx(input logic [2:0] f3);
      return {f3[1], f3[1] | f3[0]};
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] hi, input logic [31:0] lo);
      logic [31:0] sh;
      sh = 32'({hi, lo} >> {off, 3'b000});
      unique case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   assign cnt_d     = cnt_q + 2'd1;
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == DONE);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wData = ram_wdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         f3_q        <= 3'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         cnt_q       <= 2'd0;
         lo_q        <= 32'd0;
         ram_we_q    <= 2'b00;
         ram_addr_q  <= 32'd0;
         ram_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (req_valid) begin
               f3_q    <= req_funct3;
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               cnt_q   <= 2'd0;
               if (!legal(req_store, req_funct3) ||
                   (!SPLIT_EN && !aligned(req_funct3, req_addr[1:0]))) begin
                  state_q <= DONE;
                  err_q   <= 1'b1;
                  rdata_q <= 32'd0;
               end else if (req_store) begin
                  state_q    <= ST;
                  ram_addr_q <= req_addr;
                  if (aligned(req_funct3, req_addr[1:0])) begin
                     ram_we_q    <= req_funct3[1:0] + 2'd1;
                     ram_wdata_q <= req_wdata;
                  end else begin
                     ram_we_q    <= 2'b01;
                     ram_wdata_q <= {24'd0, req_wdata[7:0]};
                  end
               end else begin
                  state_q    <= LD0;
                  ram_addr_q <= {req_addr[31:2], 2'b00};
               end
            end
            ST: begin
               if (aligned(f3_q, addr_q[1:0]) || cnt_q == last_idx(f3_q)) begin
                  state_q  <= DONE;
                  ram_we_q <= 2'b00;
                  err_q    <= 1'b0;
                  rdata_q  <= 32'd0;
               end else begin
                  cnt_q       <= cnt_d;
                  ram_addr_q  <= addr_q + {30'd0, cnt_d};
                  ram_wdata_q <= {24'd0, wdata_q[{cnt_d, 3'b000} +: 8]};
               end
            end
            LD0: begin
               lo_q <= ram_rData;
               if (SPLIT_EN && crossing(f3_q, addr_q[1:0])) begin
                  state_q    <= LD1;
                  ram_addr_q <= ram_addr_q + 32'd4;
               end else begin
                  state_q <= DONE;
                  err_q   <= 1'b0;
                  rdata_q <= extend(f3_q, addr_q[1:0], 32'd0, ram_rData);
               end
            end
            LD1: begin
               state_q <= DONE;
               err_q   <= 1'b0;
               rdata_q <= extend(f3_q, addr_q[1:0], ram_rData, lo_q);
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array RAM model, write log, and a response
// scoreboard; SPLIT_EN=1 and SPLIT_EN=0 instances side by side.
`timescale 1ns/1ps
module tb_lsu_ctrl;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  lat;
   } rsp_t;

   typedef struct packed {
      logic [1:0]  we;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, req_store, rsp_valid, rsp_err;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata, rsp_rdata, ram_addr, ram_wData, ram_rData;
   logic [1:0]  ram_we;

   logic        req_valid0, req_ready0, req_store0, rsp_valid0, rsp_err0;
   logic [2:0]  req_funct30;
   logic [31:0] req_addr0, req_wdata0, rsp_rdata0, ram_addr0, ram_wData0;
   logic [31:0] ram_rData0 = 32'h1234_5678;
   logic [1:0]  ram_we0;

   logic [7:0] mem  [256];
   logic [7:0] refm [256];
   rsp_t sb[$];
   wr_t  wlog[$];
   int   n_run = 0;
   int   n_fail = 0;

   lsu_ctrl #(.SPLIT_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wData(ram_wData), .ram_rData(ram_rData)
   );

   lsu_ctrl #(.SPLIT_EN(1'b0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_store(req_store0), .req_funct3(req_funct30), .req_addr(req_addr0),
      .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
      .rsp_err(rsp_err0), .ram_we(ram_we0), .ram_addr(ram_addr0),
      .ram_wData(ram_wData0), .ram_rData(ram_rData0)
   );

   assign ram_rData = {mem[{ram_addr[7:2], 2'd3}], mem[{ram_addr[7:2], 2'd2}],
                       mem[{ram_addr[7:2], 2'd1}], mem[{ram_addr[7:2], 2'd0}]};

   always @(posedge clk) begin
      if (ram_we != 2'b00) begin
         wlog.push_back({ram_we, ram_addr, ram_wData});
         for (int i = 0; i < (ram_we == 2'b01 ? 1 : ram_we == 2'b10 ? 2 : 4); i++)
            mem[8'(ram_addr[7:0] + 8'(i))] <= ram_wData[8*i +: 8];
      end
   end

   task automatic issue(input bit d0, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input rsp_t ex);
      int w = 0;
      @(negedge clk);
      while (!(d0 ? req_ready0 : req_ready) && w < 20) begin
         @(negedge clk);
         w++;
      end
      n_run++;
      if (w >= 20) begin
         n_fail++;
         $display("FAIL ready_wait: req_ready stayed %b, required 1", 1'b0);
      end
      if (d0) begin
         req_valid0 = 1'b1; req_store0 = st; req_funct30 = f3;
         req_addr0 = a; req_wdata0 = wd;
      end else begin
         req_valid = 1'b1; req_store = st; req_funct3 = f3;
         req_addr = a; req_wdata = wd;
      end
      sb.push_back(ex);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_valid0 = 1'b0;
      req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
      req_store = 1'($urandom);
   endtask

   task automatic wait_rsp(input bit d0, output logic [31:0] rd,
                           output logic er, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(d0 ? rsp_valid0 : rsp_valid) && lat < 20);
      rd = d0 ? rsp_rdata0 : rsp_rdata;
      er = d0 ? rsp_err0 : rsp_err;
      if (!(d0 ? rsp_valid0 : rsp_valid)) begin
         lat = 255;
         rd = 'x;
      end
   endtask

   task automatic xact(input bit d0, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input rsp_t ex,
                       output rsp_t got, output rsp_t exp);
      logic [31:0] rd;
      logic er;
      int lat;
      issue(d0, st, f3, a, wd, ex);
      wait_rsp(d0, rd, er, lat);
      got = {rd, er, 8'(lat)};
      exp = sb.pop_front();
   endtask

   task automatic test_reset();
      n_run++;
      if ({req_ready, rsp_valid, rsp_err, ram_we} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b, required 10000",
                  {req_ready, rsp_valid, rsp_err, ram_we});
      end
      n_run++;
      if ({ram_addr, ram_wData, rsp_rdata} !== 96'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h, required 0", {ram_addr, ram_wData, rsp_rdata});
      end
      n_run++;
      if (req_ready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready0: got %b, required 1", req_ready0);
      end
   endtask

   task automatic test_aligned_word();
      rsp_t g, e;
      wlog.delete();
      xact(0, 1, 3'b010, 32'h8, 32'hDEAD_BEEF, {32'd0, 1'b0, 8'd2}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL sw_aligned rsp: got %h, required %h", g, e);
      end
      n_run++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_in_done: got %b, required 0", req_ready);
      end
      n_run++;
      if (wlog.size() != 1 || wlog[0] !== {2'b11, 32'h8, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL sw_aligned wr: got n=%0d %h, required n=1 %h", wlog.size(),
                  wlog.size() ? wlog[0] : '0, {2'b11, 32'h8, 32'hDEAD_BEEF});
      end
      xact(0, 0, 3'b010, 32'h8, 32'h0, {32'hDEAD_BEEF, 1'b0, 8'd2}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL lw_aligned: got %h, required %h", g, e);
      end
   endtask

   task automatic test_byte();
      rsp_t g, e;
      wlog.delete();
      xact(0, 1, 3'b000, 32'h5, 32'h0000_00A5, {32'd0, 1'b0, 8'd2}, g, e);
      n_run++;
      if (g !== e || wlog.size() != 1 || wlog[0] !== {2'b01, 32'h5, 32'hA5}) begin
         n_fail++;
         $display("FAIL sb: got %h n=%0d, required %h n=1", g, wlog.size(), e);
      end
      xact(0, 0, 3'b000, 32'h5, 32'h0, {32'hFFFF_FFA5, 1'b0, 8'd2}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL lb: got %h, required %h", g, e);
      end
      xact(0, 0, 3'b100, 32'h5, 32'h0, {32'h0000_00A5, 1'b0, 8'd2}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL lbu: got %h, required %h", g, e);
      end
   endtask

   task automatic test_misaligned_store();
      rsp_t g, e;
      wr_t w;
      wlog.delete();
      xact(0, 1, 3'b010, 32'h3, 32'h4433_2211, {32'd0, 1'b0, 8'd5}, g, e);
      n_run++;
      if (g !== e || wlog.size() != 4) begin
         n_fail++;
         $display("FAIL sw_split rsp: got %h n=%0d, required %h n=4", g, wlog.size(), e);
      end
      for (int i = 0; i < 4 && i < wlog.size(); i++) begin
         w = {2'b01, 32'(3 + i), 32'(8'h11 * (i + 1))};
         n_run++;
         if (wlog[i] !== w) begin
            n_fail++;
            $display("FAIL sw_split wr%0d: got %h, required %h", i, wlog[i], w);
         end
      end
      xact(0, 0, 3'b010, 32'h3, 32'h0, {32'h4433_2211, 1'b0, 8'd3}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL lw_split: got %h, required %h", g, e);
      end
   endtask

   task automatic test_half();
      rsp_t g, e;
      xact(0, 1, 3'b000, 32'h7, 32'h80, {32'd0, 1'b0, 8'd2}, g, e);
      xact(0, 1, 3'b000, 32'h8, 32'h12, {32'd0, 1'b0, 8'd2}, g, e);
      xact(0, 0, 3'b001, 32'h7, 32'h0, {32'h0000_1280, 1'b0, 8'd3}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL lh_cross: got %h, required %h", g, e);
      end
      xact(0, 1, 3'b000, 32'h1, 32'hFE, {32'd0, 1'b0, 8'd2}, g, e);
      xact(0, 1, 3'b000, 32'h2, 32'hFF, {32'd0, 1'b0, 8'd2}, g, e);
      xact(0, 0, 3'b101, 32'h1, 32'h0, {32'h0000_FFFE, 1'b0, 8'd2}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL lhu_off1: got %h, required %h", g, e);
      end
      xact(0, 0, 3'b001, 32'h1, 32'h0, {32'hFFFF_FFFE, 1'b0, 8'd2}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL lh_off1: got %h, required %h", g, e);
      end
   endtask

   task automatic test_errors();
      rsp_t g, e;
      wlog.delete();
      xact(0, 0, 3'b011, 32'h0, 32'h0, {32'd0, 1'b1, 8'd1}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL ld_f3_011: got %h, required %h", g, e);
      end
      xact(0, 1, 3'b100, 32'h10, 32'h55, {32'd0, 1'b1, 8'd1}, g, e);
      n_run++;
      if (g !== e || wlog.size() != 0) begin
         n_fail++;
         $display("FAIL st_f3_100: got %h n=%0d, required %h n=0", g, wlog.size(), e);
      end
      xact(1, 0, 3'b010, 32'h2, 32'h0, {32'd0, 1'b1, 8'd1}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL nosplit_lw2: got %h, required %h", g, e);
      end
      xact(1, 0, 3'b010, 32'h0, 32'h0, {32'h1234_5678, 1'b0, 8'd2}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL nosplit_lw0: got %h, required %h", g, e);
      end
      xact(1, 0, 3'b001, 32'h2, 32'h0, {32'h0000_1234, 1'b0, 8'd2}, g, e);
      n_run++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL nosplit_lh2: got %h, required %h", g, e);
      end
      xact(1, 1, 3'b001, 32'h1, 32'h0, {32'd0, 1'b1, 8'd1}, g, e);
      n_run++;
      if (g !== e || ram_we0 !== 2'b00) begin
         n_fail++;
         $display("FAIL nosplit_sh1: got %h we=%b, required %h we=00", g, ram_we0, e);
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      wlog.delete();
      issue(0, 1, 3'b001, 32'h1, 32'h0000_BBAA, '0);
      sb.delete();
      @(posedge clk);
      #1;
      n_run++;
      if ({ram_we, ram_addr} !== {2'b01, 32'h2}) begin
         n_fail++;
         $display("FAIL rst_mid pre: got %h, required %h", {ram_we, ram_addr}, {2'b01, 32'h2});
      end
      reset = 1'b1;
      #1;
      n_run++;
      if ({ram_we, req_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL rst_mid ctl: got %b, required 001", {ram_we, req_ready});
      end
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      n_run++;
      if (seen != 0 || wlog.size() != 1 || mem[1] !== 8'hAA || mem[2] !== 8'hFF) begin
         n_fail++;
         $display("FAIL rst_mid mem: got rsp=%0d n=%0d m1=%h m2=%h, required 0 1 aa ff",
                  seen, wlog.size(), mem[1], mem[2]);
      end
   endtask

   task automatic test_back_to_back();
      rsp_t g, e;
      logic [2:0] lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int i = 0; i < 256; i++) refm[i] = mem[i];
      for (int it = 0; it < 12; it++) begin
         logic [31:0] a, wd, v;
         logic [2:0] f3;
         int sz, off;
         a = 32'($urandom_range(32, 95));
         wd = $urandom;
         f3 = 3'($urandom_range(0, 2));
         sz = 1 << f3[1:0];
         off = int'(a[1:0]);
         for (int b = 0; b < sz; b++) refm[8'(a[7:0] + 8'(b))] = wd[8*b +: 8];
         xact(0, 1, f3, a, wd,
              {32'd0, 1'b0, 8'((sz == 1 || off % sz == 0) ? 2 : sz + 1)}, g, e);
         n_run++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL b2b st%0d f3=%0d a=%h: got %h, required %h", it, f3, a, g, e);
         end
         a = a + 32'($urandom_range(0, 3));
         f3 = lf3[$urandom_range(0, 4)];
         sz = 1 << f3[1:0];
         off = int'(a[1:0]);
         v = 32'd0;
         for (int b = 0; b < sz; b++) v[8*b +: 8] = refm[8'(a[7:0] + 8'(b))];
         if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
         if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
         xact(0, 0, f3, a, 32'h0, {v, 1'b0, 8'((off + sz > 4) ? 3 : 2)}, g, e);
         n_run++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL b2b ld%0d f3=%0d a=%h: got %h, required %h", it, f3, a, g, e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      req_valid0 = 1'b0; req_store0 = 1'b0; req_funct30 = 3'd0;
      req_addr0 = 32'd0; req_wdata0 = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      test_aligned_word();
      test_byte();
      test_misaligned_store();
      test_half();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
